// File: rtl/laser_pkg.sv
// Shared constants, state encoding and distance helpers for the laser host
// and any engine-side code that needs the same coverage rule.
package laser_pkg;

  localparam int NUM_POINTS = 40;
  localparam int RADIUS_SQ  = 16;
  localparam int COORD_W    = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PULSE  = 3'd1,
    S_STREAM = 3'd2,
    S_WAIT   = 3'd3,
    S_SCORE  = 3'd4,
    S_REPORT = 3'd5
  } laser_state_e;

  // Plain constants keep the state register a simple logic vector
  localparam logic [2:0] ST_IDLE   = S_IDLE;
  localparam logic [2:0] ST_PULSE  = S_PULSE;
  localparam logic [2:0] ST_STREAM = S_STREAM;
  localparam logic [2:0] ST_WAIT   = S_WAIT;
  localparam logic [2:0] ST_SCORE  = S_SCORE;
  localparam logic [2:0] ST_REPORT = S_REPORT;

  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // 15*15 + 15*15 = 450 fits in 9 bits, so the sum never wraps
  function automatic logic [8:0] dist_sq(input logic [COORD_W-1:0] dx,
                                         input logic [COORD_W-1:0] dy);
    logic [7:0] sx;
    logic [7:0] sy;
    sx = {4'b0, dx} * {4'b0, dx};
    sy = {4'b0, dy} * {4'b0, dy};
    return {1'b0, sx} + {1'b0, sy};
  endfunction

endpackage

// File: rtl/laser_cover_chk.sv
// Combinational check: is one point inside either of two fixed-radius circles.
module laser_cover_chk
  import laser_pkg::*;
(
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  logic [COORD_W-1:0] c1x,
  input  logic [COORD_W-1:0] c1y,
  input  logic [COORD_W-1:0] c2x,
  input  logic [COORD_W-1:0] c2y,
  output logic               covered
);

  logic [8:0] d1;
  logic [8:0] d2;

  assign d1 = dist_sq(abs_diff(px, c1x), abs_diff(py, c1y));
  assign d2 = dist_sq(abs_diff(px, c2x), abs_diff(py, c2y));

  // A point inside both circles still yields a single covered bit
  assign covered = (d1 <= 9'(RADIUS_SQ)) || (d2 <= 9'(RADIUS_SQ));

endmodule

// File: rtl/laser_host.sv
// Laser host: holds a 40-point table, streams it to the circle engine and
// reports the result. Define LASER_HOST_SCORE_EN to build the coverage scorer.
module laser_host
  import laser_pkg::*;
#(
  parameter int TIMEOUT = 200000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LOAD_EN,
  input  logic [5:0] LOAD_IDX,
  input  logic [3:0] LOAD_X,
  input  logic [3:0] LOAD_Y,
  input  logic       START,
  output logic       ENG_RST,
  output logic [3:0] X,
  output logic [3:0] Y,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  input  logic       ENG_DONE,
  output logic       BUSY,
  output logic       VALID,
  output logic       TIMEOUT_ERR,
  output logic [5:0] SCORE
);

  localparam logic [5:0]  LAST_IDX  = 6'(NUM_POINTS - 1);
  localparam logic [19:0] WAIT_LAST = 20'(TIMEOUT - 1);

  logic [2:0]  state;
  logic [5:0]  idx;
  logic [19:0] wait_cnt;
  logic [3:0]  c1x_q, c1y_q, c2x_q, c2y_q;
  logic        valid_q;
  logic        terr_q;
  logic [5:0]  score_q;
  logic [3:0]  mem_x [NUM_POINTS];
  logic [3:0]  mem_y [NUM_POINTS];
  logic [3:0]  pt_x;
  logic [3:0]  pt_y;
  logic        covered;
`ifdef LASER_HOST_SCORE_EN
  logic [5:0]  acc;
`endif

  // The point table deliberately has no reset so it survives RST
  always_ff @(posedge CLK) begin
    if (state == ST_IDLE && LOAD_EN && LOAD_IDX < 6'(NUM_POINTS)) begin
      mem_x[LOAD_IDX] <= LOAD_X;
      mem_y[LOAD_IDX] <= LOAD_Y;
    end
  end

  assign pt_x = mem_x[idx];
  assign pt_y = mem_y[idx];

  laser_cover_chk u_cover (
    .px      (pt_x),
    .py      (pt_y),
    .c1x     (c1x_q),
    .c1y     (c1y_q),
    .c2x     (c2x_q),
    .c2y     (c2y_q),
    .covered (covered)
  );

`ifndef LASER_HOST_SCORE_EN
  logic unused_cover;
  assign unused_cover = covered;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      idx      <= '0;
      wait_cnt <= '0;
      c1x_q    <= '0;
      c1y_q    <= '0;
      c2x_q    <= '0;
      c2y_q    <= '0;
      valid_q  <= 1'b0;
      terr_q   <= 1'b0;
      score_q  <= '0;
`ifdef LASER_HOST_SCORE_EN
      acc      <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            state   <= ST_PULSE;
            valid_q <= 1'b0;
            terr_q  <= 1'b0;
            score_q <= '0;
          end
        end
        ST_PULSE: begin
          state <= ST_STREAM;
          idx   <= '0;
        end
        ST_STREAM: begin
          if (idx == LAST_IDX) begin
            state    <= ST_WAIT;
            idx      <= '0;
            wait_cnt <= '0;
          end else begin
            idx <= idx + 6'd1;
          end
        end
        // A DONE on the final allowed cycle still wins over the timeout
        ST_WAIT: begin
          if (ENG_DONE) begin
            c1x_q <= C1X;
            c1y_q <= C1Y;
            c2x_q <= C2X;
            c2y_q <= C2Y;
`ifdef LASER_HOST_SCORE_EN
            state <= ST_SCORE;
            acc   <= '0;
`else
            state   <= ST_REPORT;
            score_q <= '0;
            valid_q <= 1'b1;
`endif
          end else if (wait_cnt == WAIT_LAST) begin
            state   <= ST_REPORT;
            terr_q  <= 1'b1;
            score_q <= '0;
            valid_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 20'd1;
          end
        end
`ifdef LASER_HOST_SCORE_EN
        ST_SCORE: begin
          acc <= acc + {5'b0, covered};
          if (idx == LAST_IDX) begin
            state   <= ST_REPORT;
            score_q <= acc + {5'b0, covered};
            valid_q <= 1'b1;
          end else begin
            idx <= idx + 6'd1;
          end
        end
`endif
        ST_REPORT: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ENG_RST     = (state == ST_PULSE);
  assign X           = (state == ST_STREAM) ? pt_x : 4'd0;
  assign Y           = (state == ST_STREAM) ? pt_y : 4'd0;
  assign BUSY        = (state == ST_PULSE) || (state == ST_STREAM) ||
                       (state == ST_WAIT)  || (state == ST_SCORE);
  assign VALID       = valid_q;
  assign TIMEOUT_ERR = terr_q;
  assign SCORE       = score_q;

endmodule

// File: tb/tb_laser_host.sv
// Scoreboard bench for laser_host: expected run results and point snapshots are
// queued by the driver and consumed by independent result and stream monitors.
`timescale 1ns/1ps
module tb_laser_host;

  localparam int TB_TIMEOUT = 150;
  localparam int NPTS       = 40;
`ifdef LASER_HOST_SCORE_EN
  localparam int SCORE_CYC = 40;
  localparam bit SCORE_ON  = 1'b1;
`else
  localparam int SCORE_CYC = 0;
  localparam bit SCORE_ON  = 1'b0;
`endif

  typedef struct {
    int score;
    int terr;
    int lat;
    int start;
  } exp_t;

  logic       CLK, RST, LOAD_EN, START, ENG_DONE;
  logic       ENG_RST, BUSY, VALID, TIMEOUT_ERR;
  logic [5:0] LOAD_IDX, SCORE;
  logic [3:0] LOAD_X, LOAD_Y, X, Y, C1X, C1Y, C2X, C2Y;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int mx [NPTS];
  int my [NPTS];
  exp_t         res_q [$];
  logic [319:0] snap_q [$];

  laser_host #(.TIMEOUT(TB_TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .LOAD_EN(LOAD_EN), .LOAD_IDX(LOAD_IDX),
    .LOAD_X(LOAD_X), .LOAD_Y(LOAD_Y), .START(START), .ENG_RST(ENG_RST),
    .X(X), .Y(Y), .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
    .ENG_DONE(ENG_DONE), .BUSY(BUSY), .VALID(VALID),
    .TIMEOUT_ERR(TIMEOUT_ERR), .SCORE(SCORE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Reference coverage count straight from the circle rule
  function automatic int model_score(input int c1x, input int c1y,
                                     input int c2x, input int c2y);
    int n = 0;
    for (int k = 0; k < NPTS; k++) begin
      int d1 = (mx[k] - c1x) * (mx[k] - c1x) + (my[k] - c1y) * (my[k] - c1y);
      int d2 = (mx[k] - c2x) * (mx[k] - c2x) + (my[k] - c2y) * (my[k] - c2y);
      if (d1 <= 16 || d2 <= 16) n++;
    end
    return n;
  endfunction

  function automatic logic [319:0] snapshot();
    logic [319:0] s;
    for (int k = 0; k < NPTS; k++) s[k*8 +: 8] = {4'(mx[k]), 4'(my[k])};
    return s;
  endfunction

  task automatic load_point(input int idx, input int x, input int y);
    @(negedge CLK);
    LOAD_EN  = 1'b1;
    LOAD_IDX = 6'(idx);
    LOAD_X   = 4'(x);
    LOAD_Y   = 4'(y);
    if (idx < NPTS) begin
      mx[idx] = x;
      my[idx] = y;
    end
    @(negedge CLK);
    LOAD_EN = 1'b0;
  endtask

  // w = WAIT cycle on which the engine answers (1-based); w = 0 means never
  task automatic apply_stimulus(input int w, input int c1x, input int c1y,
                                input int c2x, input int c2y,
                                input bit spurious, input bit intrude);
    exp_t e;
    int   rep;
    e.terr  = (w == 0) ? 1 : 0;
    e.score = (w == 0 || !SCORE_ON) ? 0 : model_score(c1x, c1y, c2x, c2y);
    rep     = (w == 0) ? (1 + NPTS + TB_TIMEOUT + 1) : (1 + NPTS + w + SCORE_CYC + 1);
    e.lat   = rep;
    @(negedge CLK);
    e.start = cyc + 1;
    res_q.push_back(e);
    snap_q.push_back(snapshot());
    START = 1'b1;
    for (int k = 1; k <= rep + 2; k++) begin
      @(negedge CLK);
      START    = 1'b0;
      LOAD_EN  = 1'b0;
      ENG_DONE = 1'b0;
      {C1X, C1Y, C2X, C2Y} = 16'($urandom);
      if (spurious && (k == 1 || k == 20)) ENG_DONE = 1'b1;
      if (w > 0 && k == NPTS + 1 + w) begin
        ENG_DONE = 1'b1;
        C1X = 4'(c1x); C1Y = 4'(c1y); C2X = 4'(c2x); C2Y = 4'(c2y);
      end
      if (intrude && (w == 0 || w >= 3) && k == NPTS + 3) begin
        START    = 1'b1;
        LOAD_EN  = 1'b1;
        LOAD_IDX = 6'($urandom_range(0, NPTS - 1));
        LOAD_X   = 4'($urandom);
        LOAD_Y   = 4'($urandom);
      end
    end
    START   = 1'b0;
    LOAD_EN = 1'b0;
    check_output("held_valid", 32'(VALID), 1);
    check_output("held_busy", 32'(BUSY), 0);
    check_output("held_score", 32'(SCORE), e.score);
    check_output("held_timeout_err", 32'(TIMEOUT_ERR), e.terr);
  endtask

  task automatic reset_mid_stream();
    @(negedge CLK);
    snap_q.push_back(snapshot());
    START = 1'b1;
    for (int k = 1; k <= NPTS / 2 + 2; k++) begin
      @(negedge CLK);
      START = 1'b0;
    end
    #2 RST = 1'b1;
    @(negedge CLK);
    check_output("abort_busy", 32'(BUSY), 0);
    check_output("abort_xy", 32'({X, Y}), 0);
    check_output("abort_valid", 32'(VALID), 0);
    check_output("abort_eng_rst", 32'(ENG_RST), 0);
    #2 RST = 1'b0;
    repeat (3) @(negedge CLK);
    check_output("post_abort_valid", 32'(VALID), 0);
  endtask

  // Result monitor: one expected entry per VALID rising edge
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        prev = 1'b0;
      end else begin
        if (VALID === 1'b1 && prev !== 1'b1) begin
          if (res_q.size() == 0) begin
            check_output("unexpected_valid", 32'(VALID), 0);
          end else begin
            e = res_q.pop_front();
            check_output("score", 32'(SCORE), e.score);
            check_output("timeout_err", 32'(TIMEOUT_ERR), e.terr);
            check_output("latency", cyc - e.start + 1, e.lat);
            check_output("busy_in_report", 32'(BUSY), 0);
          end
        end
        prev = VALID;
      end
    end
  end

  // Stream monitor: ENG_RST pulse, then 40 ordered points, then X/Y back to 0
  initial begin
    int           sk;
    logic [319:0] cur;
    logic [7:0]   pt;
    sk  = 0;
    cur = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        sk = 0;
      end else if (sk == 0) begin
        if (ENG_RST === 1'b1) begin
          if (snap_q.size() == 0) begin
            check_output("unexpected_eng_rst", 32'(ENG_RST), 0);
          end else begin
            cur = snap_q.pop_front();
            check_output("pulse_xy", 32'({X, Y}), 0);
            check_output("pulse_busy", 32'(BUSY), 1);
            sk = 1;
          end
        end
      end else if (sk <= NPTS) begin
        pt = cur[(sk-1)*8 +: 8];
        check_output($sformatf("stream_point_%0d", sk - 1), 32'({ENG_RST, X, Y}),
                     32'({1'b0, pt}));
        sk++;
      end else begin
        check_output("wait_xy", 32'({ENG_RST, X, Y}), 0);
        sk = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    RST = 1'b1; LOAD_EN = 1'b0; LOAD_IDX = '0; LOAD_X = '0; LOAD_Y = '0;
    START = 1'b0; ENG_DONE = 1'b0;
    C1X = '0; C1Y = '0; C2X = '0; C2Y = '0;
    for (int k = 0; k < NPTS; k++) begin
      mx[k] = 0;
      my[k] = 0;
    end
    repeat (3) @(negedge CLK);
    check_output("rst_busy", 32'(BUSY), 0);
    check_output("rst_valid", 32'(VALID), 0);
    check_output("rst_timeout_err", 32'(TIMEOUT_ERR), 0);
    check_output("rst_score", 32'(SCORE), 0);
    check_output("rst_xy", 32'({X, Y}), 0);
    check_output("rst_eng_rst", 32'(ENG_RST), 0);
    #2 RST = 1'b0;

    // Ordered ramp table, plus writes to indices past the table
    for (int k = 0; k < NPTS; k++) load_point(k, k % 16, k / 16);
    load_point(45, 15, 15);
    load_point(63, 7, 7);
    apply_stimulus(100, 2, 1, 10, 0, 1'b0, 1'b0);

    for (int k = 0; k < NPTS; k++) load_point(k, 5, 5);
    apply_stimulus(30, 5, 5, 0, 0, 1'b1, 1'b1);
    apply_stimulus(7, 5, 5, 6, 6, 1'b0, 1'b0);

    for (int k = 0; k < NPTS; k++) load_point(k, 0, 0);
    apply_stimulus(12, 4, 0, 15, 15, 1'b0, 1'b0);
    apply_stimulus(12, 3, 3, 15, 15, 1'b0, 1'b0);

    repeat (5) begin
      for (int i = 0; i < 50; i++)
        load_point(int'($urandom_range(0, 63)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)));
      w = int'($urandom_range(3, 140));
      apply_stimulus(w, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    apply_stimulus(TB_TIMEOUT, 8, 8, 2, 13, 1'b0, 1'b0);
    apply_stimulus(0, 0, 0, 0, 0, 1'b1, 1'b1);

    reset_mid_stream();
    apply_stimulus(1, 7, 3, 12, 9, 1'b0, 1'b0);

    repeat (3) @(negedge CLK);
    check_output("pending_results", res_q.size(), 0);
    check_output("pending_streams", snap_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/laser_host.md
LASER_HOST -- requirements
Module: laser_host

Interface
REQ-001 SHALL have parameter TIMEOUT, default 200000, max cycles in WAIT before abort (20-bit counter).
REQ-002 SHALL have port CLK input 1 clock, rising edge active.
REQ-003 SHALL have port RST input 1 reset, asynchronous, active-high.
REQ-004 SHALL have port LOAD_EN input 1 write strobe into point memory.
REQ-005 SHALL have port LOAD_IDX input 6 point index 0..39.
REQ-006 SHALL have port LOAD_X / LOAD_Y input 4 each, point coordinates.
REQ-007 SHALL have port START input 1 begin one run.
REQ-008 SHALL have port ENG_RST output 1 engine reset pulse.
REQ-009 SHALL have port X / Y output 4 each, point stream to engine.
REQ-010 SHALL have port C1X, C1Y, C2X, C2Y input 4 each, engine circle centres.
REQ-011 SHALL have port ENG_DONE input 1 engine result valid.
REQ-012 SHALL have port BUSY output 1, VALID output 1, TIMEOUT_ERR output 1, SCORE output 6 (covered point count).

Function
REQ-013 SHALL implement states IDLE, PULSE, STREAM, WAIT, SCORE, REPORT.
REQ-014 IDLE: LOAD_EN with LOAD_IDX<40 writes memory[LOAD_IDX] next edge; LOAD_IDX>=40 ignored; LOAD_EN outside IDLE ignored.
REQ-015 IDLE + START -> PULSE; VALID and TIMEOUT_ERR clear on that edge.
REQ-016 PULSE lasts exactly 1 cycle with ENG_RST=1; ENG_RST=0 in every other state.
REQ-017 STREAM lasts exactly 40 cycles; X/Y SHALL present memory[k] during STREAM cycle k (k=0..39), point 0 in first cycle after ENG_RST falls.
REQ-018 X/Y SHALL be 0 outside STREAM.
REQ-019 ENG_DONE during PULSE/STREAM SHALL be ignored.
REQ-020 WAIT: first cycle with ENG_DONE=1 captures C1X..C2Y into internal registers, -> SCORE.
REQ-021 WAIT: cycle counter reaching TIMEOUT without ENG_DONE -> REPORT with TIMEOUT_ERR=1, SCORE=0.
REQ-022 SCORE: one point per cycle, 40 cycles; point covered if (dx1^2+dy1^2<=16) OR (dx2^2+dy2^2<=16), dx/dy = 4-bit absolute difference, sums 9-bit unsigned, no overflow.
REQ-023 point inside both circles SHALL count once; SCORE range 0..40.
REQ-024 REPORT: VALID=1, SCORE and TIMEOUT_ERR held stable, -> IDLE next cycle; VALID, SCORE, TIMEOUT_ERR stay held in IDLE until next START.
REQ-025 BUSY=1 in PULSE, STREAM, WAIT, SCORE; 0 in IDLE, REPORT.
REQ-026 START outside IDLE SHALL be ignored.
REQ-027 Latency START -> VALID = 1+40+W+40+1 cycles, W = WAIT cycles including capture cycle.

Reset
REQ-028 RST SHALL force IDLE; ENG_RST=0, X=Y=0, BUSY=0, VALID=0, TIMEOUT_ERR=0, SCORE=0, captured centres 0, counters 0.
REQ-029 Point memory SHALL not be reset; contents retained across RST.
REQ-030 RST mid-run SHALL abort immediately with no VALID pulse.

Configuration
REQ-031 Macro LASER_HOST_SCORE_EN defined: SCORE state and scorer compiled in per REQ-022.
REQ-032 Macro absent: SCORE state omitted, WAIT capture -> REPORT directly, SCORE tied 0, latency reduced by 40.

Structure
REQ-033 Shared package laser_pkg SHALL hold NUM_POINTS=40, RADIUS_SQ=16, COORD_W=4, state enum typedef.
REQ-034 Sub-module laser_cover_chk SHALL compute in-circle for one point vs two centres, combinational, reusable by engine-side code.

Verification
REQ-035 Load points k=(k%16, k/16), START, model engine returns DONE after 100 cycles -> ENG_RST one cycle, 40 ordered points, VALID at cycle 182.
REQ-036 All 40 points at (5,5), centres (5,5),(0,0) -> SCORE=40.
REQ-037 Point (0,0), centre (4,0) -> covered; point (0,0), centre (3,3) (dist^2=18) -> not covered.
REQ-038 Engine never asserts DONE, TIMEOUT=50 -> TIMEOUT_ERR=1, SCORE=0, VALID in REPORT.
REQ-039 RST at STREAM cycle 20 -> BUSY=0, X=Y=0 next cycle; later START reuses memory, stream intact.
REQ-040 START and LOAD_EN during WAIT -> ignored, memory unchanged, single VALID.
